// File: rtl/gba_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gba_video_pkg
// Purpose  : Shared GBA video definitions: screen geometry, pixel formats,
//            streamer FSM encoding and the BGR555 -> RGB666 expansion used
//            by both the line streamer and the video output block.
// Revision : 1.0  initial release
// ============================================================================
package gba_video_pkg;

    localparam int GBA_WIDTH  = 240;
    localparam int GBA_HEIGHT = 160;

    typedef logic [14:0] bgr555_t;
    typedef logic [17:0] rgb666_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } streamer_state_e;

    // Each 5-bit channel widens to 6 bits by replicating its MSB into the
    // new LSB, so full scale maps to full scale without any adder.
    function automatic rgb666_t bgr555_to_rgb666(input bgr555_t c);
        return {c[4:0], c[4], c[9:5], c[9], c[14:10], c[14]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gba_line_streamer.sv
`default_nettype none
// ============================================================================
// Module   : gba_line_streamer
// Purpose  : Reads a finished scanline back from the PPU's double-banked
//            BGR555 line RAM and emits one RGB666 framebuffer write per pixel.
// Ports    : clk, reset          core clock, synchronous active-high reset
//            line_valid_i        one-cycle "scanline ready" pulse
//            line_num_i/bank_i   scanline index and line RAM bank
//            lb_addr_o/rdata_i   line RAM read port {bank,x}, 1-cycle latency
//            pixel_*_o           framebuffer write (data, x, y, strobe)
//            busy_o              streaming or a request is pending
//            overflow_o          sticky: a request was dropped
// Revision : 1.0  initial release
// ============================================================================
module gba_line_streamer
    import gba_video_pkg::*;
#(
    parameter int WIDTH     = GBA_WIDTH,
    parameter int HEIGHT    = GBA_HEIGHT,
    parameter int PIXEL_GAP = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_valid_i,
    input  logic [7:0]  line_num_i,
    input  logic        line_bank_i,
    output logic [8:0]  lb_addr_o,
    input  logic [14:0] lb_rdata_i,
    output logic [17:0] pixel_data_o,
    output logic [7:0]  pixel_x_o,
    output logic [7:0]  pixel_y_o,
    output logic        pixel_we_o,
    output logic        busy_o,
    output logic        overflow_o
);

    localparam int              GAP_W        = (PIXEL_GAP > 0) ? $clog2(PIXEL_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] c_gap_reload = GAP_W'(PIXEL_GAP);
    localparam logic [7:0]      c_last_x     = 8'(WIDTH - 1);
    localparam logic [8:0]      c_height     = 9'(HEIGHT);

    streamer_state_e   state_q, state_d;
    logic              bank_q, bank_d;
    logic [7:0]        line_q, line_d;
    logic [8:0]        addr_q, addr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              rd_q, rd_d;          // a new address is on lb_addr_o this cycle
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        pend_line_q, pend_line_d;
    logic              pend_bank_q, pend_bank_d;
    logic              ovf_q, ovf_d;
    logic              we_q;
    logic [7:0]        pix_x_q;
    rgb666_t           pix_hold_q;

    logic              w_req;
    logic              w_start_pend;
    logic              w_start_req;
    logic [7:0]        w_start_line;
    logic              w_start_bank;
    rgb666_t           w_pix_data;

    // Requests for lines beyond the visible area (VBlank) are not requests.
    assign w_req        = line_valid_i && ({1'b0, line_num_i} < c_height);
    // A pending line always wins over a fresh request when the engine is idle.
    assign w_start_pend = (state_q == ST_IDLE) && pend_valid_q;
    assign w_start_req  = (state_q == ST_IDLE) && !pend_valid_q && w_req;
    assign w_start_line = pend_valid_q ? pend_line_q : line_num_i;
    assign w_start_bank = pend_valid_q ? pend_bank_q : line_bank_i;

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        line_d       = line_q;
        addr_d       = addr_q;
        gap_d        = gap_q;
        rd_d         = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_line_d  = pend_line_q;
        pend_bank_d  = pend_bank_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (w_start_pend || w_start_req) begin
                    state_d = ST_READ;
                    bank_d  = w_start_bank;
                    line_d  = w_start_line;
                    addr_d  = {w_start_bank, 8'd0};
                    rd_d    = 1'b1;
                    gap_d   = c_gap_reload;
                end
            end
            ST_READ: begin
                if (addr_q[7:0] == c_last_x) begin
                    state_d = ST_DRAIN;
                end else if (gap_q == '0) begin
                    addr_d = {bank_q, addr_q[7:0] + 8'd1};
                    rd_d   = 1'b1;
                    gap_d  = c_gap_reload;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pending slot: a slot being consumed this cycle counts as free.
        if (w_start_pend) begin
            pend_valid_d = 1'b0;
        end
        if (w_req && !w_start_req) begin
            if (!pend_valid_q || w_start_pend) begin
                pend_valid_d = 1'b1;
                pend_line_d  = line_num_i;
                pend_bank_d  = line_bank_i;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Read data arrives the cycle after its address, which is exactly when
    // the registered strobe for that read is high, so the colour is taken
    // straight from the RAM and held afterwards.
    assign w_pix_data = we_q ? bgr555_to_rgb666(lb_rdata_i) : pix_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bank_q       <= 1'b0;
            line_q       <= 8'd0;
            addr_q       <= 9'd0;
            gap_q        <= '0;
            rd_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_line_q  <= 8'd0;
            pend_bank_q  <= 1'b0;
            ovf_q        <= 1'b0;
            we_q         <= 1'b0;
            pix_x_q      <= 8'd0;
            pix_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            gap_q        <= gap_d;
            rd_q         <= rd_d;
            pend_valid_q <= pend_valid_d;
            pend_line_q  <= pend_line_d;
            pend_bank_q  <= pend_bank_d;
            ovf_q        <= ovf_d;
            we_q         <= rd_q;
            if (rd_q) begin
                pix_x_q <= addr_q[7:0];
            end
            pix_hold_q   <= w_pix_data;
        end
    end

    assign lb_addr_o    = addr_q;
    assign pixel_data_o = w_pix_data;
    assign pixel_x_o    = pix_x_q;
    assign pixel_y_o    = line_q;
    assign pixel_we_o   = we_q;
    assign busy_o       = (state_q != ST_IDLE) || pend_valid_q;
    assign overflow_o   = ovf_q;

endmodule
`default_nettype wire
